// File: rtl/spi_pkg.sv
// Shared definitions for the SPI mode-0 master: frame width, the FSM state
// encoding, and the legal range of the SCLK half-period divider.
package spi_pkg;

  localparam int FRAME_BITS      = 8;
  // Below 4 clk cycles per half-period the slave's 2-flop synchronisers
  // can miss SCLK edges.
  localparam int SPI_MIN_CLK_DIV = 4;
  // The divider counter is 8 bits wide.
  localparam int SPI_MAX_CLK_DIV = 255;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    XFER,
    HOLD,
    GAP
  } spi_master_state_t;

endpackage

// File: rtl/spi_master_module_if.sv
// Request/response bus of the SPI master.
//   tx_valid/tx_ready/tx_data : byte request handshake (accept = valid & ready)
//   rx_data/rx_valid          : received byte plus one-cycle update strobe
//   busy                      : frame in progress
// The master modport is the requester; the slave modport is the SPI master
// block itself.
interface spi_master_module_if;
  import spi_pkg::*;

  logic                  tx_valid;
  logic                  tx_ready;
  logic [FRAME_BITS-1:0] tx_data;
  logic [FRAME_BITS-1:0] rx_data;
  logic                  rx_valid;
  logic                  busy;

  modport master (
    output tx_valid, tx_data,
    input  tx_ready, rx_data, rx_valid, busy
  );

  modport slave (
    input  tx_valid, tx_data,
    output tx_ready, rx_data, rx_valid, busy
  );

endinterface

// File: rtl/spi_clk_div.sv
// SCLK half-period timer for the SPI master.
//   clk, reset : system clock, synchronous active-high reset
//   en         : run the timer; low clears the counter
//   half_tick  : one-cycle pulse every CLK_DIV cycles while en is high
module spi_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic half_tick
);

  localparam logic [7:0] DIV    = 8'(CLK_DIV);
  localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);

  logic [7:0] cnt_q, cnt_d;

  // The counter sits at 0 while disabled. The first enabled cycle (count 0)
  // loads CLK_DIV-1 so the first tick lands on the CLK_DIV-th enabled cycle;
  // after that the terminal count 1 reloads CLK_DIV for a steady period.
  assign half_tick = en && (cnt_q == 8'd1);

  always_comb begin
    cnt_d = cnt_q;
    if (!en) begin
      cnt_d = 8'd0;
    end else if (cnt_q == 8'd0) begin
      cnt_d = DIV_M1;
    end else if (cnt_q == 8'd1) begin
      cnt_d = DIV;
    end else begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_master_module.sv
// SPI mode-0 (CPOL=0, CPHA=0) master, one 8-bit full-duplex frame per
// accepted request, MSB first.
//   clk, reset : system clock, synchronous active-high reset
//   bus        : request/response bus (slave modport)
//   sclk_out   : SPI clock, idles low
//   ss_n_out   : active-low slave select
//   mosi_out   : serial data out
//   miso_in    : serial data in (asynchronous, synchronised here)
//
// state | meaning
// IDLE  | tx_ready high, waiting for a request
// SETUP | select asserted, MSB on MOSI, one half-period before first rise
// XFER  | 8 SCLK periods; sample on rise, shift on fall
// HOLD  | select held low one half-period after the last fall
// GAP   | select released one half-period before the next request
module spi_master_module
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                clk,
  input  logic                reset,
  spi_master_module_if.slave  bus,
  output logic                sclk_out,
  output logic                ss_n_out,
  output logic                mosi_out,
  input  logic                miso_in
);

  if (CLK_DIV < SPI_MIN_CLK_DIV || CLK_DIV > SPI_MAX_CLK_DIV) begin : g_bad_clk_div
    $error("spi_master_module: CLK_DIV=%0d outside %0d..%0d",
           CLK_DIV, SPI_MIN_CLK_DIV, SPI_MAX_CLK_DIV);
  end

  localparam logic [2:0] LAST_BIT = 3'(FRAME_BITS - 1);

  spi_master_state_t     state_q, state_d;
  logic [FRAME_BITS-1:0] tx_sh_q, tx_sh_d;
  logic [FRAME_BITS-1:0] rx_sh_q, rx_sh_d;
  logic [FRAME_BITS-1:0] rx_data_q, rx_data_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic                  sclk_q, sclk_d;
  logic                  ss_n_q, ss_n_d;
  logic                  mosi_q, mosi_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  tx_ready_q, tx_ready_d;
  logic                  busy_q, busy_d;
  logic                  miso_sync1_q, miso_sync2_q;

  logic div_en;
  logic half_tick;
  logic accept;

  assign div_en = (state_q != IDLE);
  assign accept = bus.tx_valid && tx_ready_q;

  spi_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .clk       (clk),
    .reset     (reset),
    .en        (div_en),
    .half_tick (half_tick)
  );

  always_comb begin
    state_d    = state_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    bit_cnt_d  = bit_cnt_q;
    sclk_d     = sclk_q;
    ss_n_d     = ss_n_q;
    mosi_d     = mosi_q;
    rx_valid_d = 1'b0;
    tx_ready_d = tx_ready_q;
    busy_d     = busy_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d    = SETUP;
          tx_sh_d    = bus.tx_data;
          rx_sh_d    = '0;
          bit_cnt_d  = 3'd0;
          ss_n_d     = 1'b0;
          sclk_d     = 1'b0;
          mosi_d     = bus.tx_data[FRAME_BITS-1];
          tx_ready_d = 1'b0;
          busy_d     = 1'b1;
        end
      end
      SETUP: begin
        // The tick that ends SETUP is also the first rising edge.
        if (half_tick) begin
          state_d = XFER;
          sclk_d  = 1'b1;
          rx_sh_d = {rx_sh_q[FRAME_BITS-2:0], miso_sync2_q};
        end
      end
      XFER: begin
        if (half_tick) begin
          if (!sclk_q) begin
            sclk_d  = 1'b1;
            rx_sh_d = {rx_sh_q[FRAME_BITS-2:0], miso_sync2_q};
          end else begin
            sclk_d = 1'b0;
            if (bit_cnt_q == LAST_BIT) begin
              // rx_sh_q already holds the 8th bit from the preceding rise.
              rx_data_d  = rx_sh_q;
              rx_valid_d = 1'b1;
              state_d    = HOLD;
            end else begin
              tx_sh_d   = {tx_sh_q[FRAME_BITS-2:0], 1'b0};
              mosi_d    = tx_sh_q[FRAME_BITS-2];
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end
        end
      end
      HOLD: begin
        if (half_tick) begin
          state_d = GAP;
          ss_n_d  = 1'b1;
          mosi_d  = 1'b0;
        end
      end
      GAP: begin
        if (half_tick) begin
          state_d    = IDLE;
          tx_ready_d = 1'b1;
          busy_d     = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      tx_sh_q      <= '0;
      rx_sh_q      <= '0;
      rx_data_q    <= '0;
      bit_cnt_q    <= 3'd0;
      sclk_q       <= 1'b0;
      ss_n_q       <= 1'b1;
      mosi_q       <= 1'b0;
      rx_valid_q   <= 1'b0;
      tx_ready_q   <= 1'b1;
      busy_q       <= 1'b0;
      miso_sync1_q <= 1'b0;
      miso_sync2_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tx_sh_q      <= tx_sh_d;
      rx_sh_q      <= rx_sh_d;
      rx_data_q    <= rx_data_d;
      bit_cnt_q    <= bit_cnt_d;
      sclk_q       <= sclk_d;
      ss_n_q       <= ss_n_d;
      mosi_q       <= mosi_d;
      rx_valid_q   <= rx_valid_d;
      tx_ready_q   <= tx_ready_d;
      busy_q       <= busy_d;
      miso_sync1_q <= miso_in;
      miso_sync2_q <= miso_sync1_q;
    end
  end

  assign sclk_out     = sclk_q;
  assign ss_n_out     = ss_n_q;
  assign mosi_out     = mosi_q;
  assign bus.tx_ready = tx_ready_q;
  assign bus.busy     = busy_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;

endmodule
